// File: rtl/fft_pkg.sv
// Shared definitions for the streaming radix-2 FFT: FSM states, twiddle
// tables for a 64-point transform (Q1.15), and index helpers.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } fft_state_t;

  localparam int unsigned TW_ENTRIES = 32;

  // cos/sin(2*pi*k/64), k=0..31; unity is clamped to the largest positive code
  localparam logic signed [15:0] COS_TAB [TW_ENTRIES] = '{
    16'sd32767,  16'sd32610,  16'sd32138,  16'sd31357,
    16'sd30273,  16'sd28899,  16'sd27245,  16'sd25330,
    16'sd23170,  16'sd20788,  16'sd18205,  16'sd15447,
    16'sd12540,  16'sd9512,   16'sd6393,   16'sd3212,
    16'sd0,      -16'sd3212,  -16'sd6393,  -16'sd9512,
    -16'sd12540, -16'sd15447, -16'sd18205, -16'sd20788,
    -16'sd23170, -16'sd25330, -16'sd27245, -16'sd28899,
    -16'sd30273, -16'sd31357, -16'sd32138, -16'sd32610
  };

  localparam logic signed [15:0] SIN_TAB [TW_ENTRIES] = '{
    16'sd0,      16'sd3212,   16'sd6393,   16'sd9512,
    16'sd12540,  16'sd15447,  16'sd18205,  16'sd20788,
    16'sd23170,  16'sd25330,  16'sd27245,  16'sd28899,
    16'sd30273,  16'sd31357,  16'sd32138,  16'sd32610,
    16'sd32767,  16'sd32610,  16'sd32138,  16'sd31357,
    16'sd30273,  16'sd28899,  16'sd27245,  16'sd25330,
    16'sd23170,  16'sd20788,  16'sd18205,  16'sd15447,
    16'sd12540,  16'sd9512,   16'sd6393,   16'sd3212
  };

  function automatic logic [5:0] bitrev(input logic [5:0] v, input int unsigned bits);
    logic [5:0] r;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < bits) r[3'(bits - 1 - i)] = v[3'(i)];
    end
    return r;
  endfunction

  // Re-express a Q1.15 table entry in Q1.(dw-1)
  function automatic logic signed [31:0] tw_q(input logic signed [15:0] v, input int unsigned dw);
    logic signed [31:0] x;
    x = {{16{v[15]}}, v};
    if (dw >= 16) return x <<< (dw - 16);
    return x >>> (16 - dw);
  endfunction

endpackage

// File: rtl/fft_bfly_unit.sv
// Combinational radix-2 DIT butterfly: X0 = A + W*B, X1 = A - W*B with
// W = cos - j*sin, trivial-twiddle bypass, rounding and scale/saturate.
module fft_bfly_unit #(
  parameter int DATA_W = 16,
  parameter int SCALE  = 1
) (
  input  logic signed [DATA_W-1:0] i_a_re,
  input  logic signed [DATA_W-1:0] i_a_im,
  input  logic signed [DATA_W-1:0] i_b_re,
  input  logic signed [DATA_W-1:0] i_b_im,
  input  logic signed [DATA_W-1:0] i_w_cos,
  input  logic signed [DATA_W-1:0] i_w_sin,
  input  logic                     i_k_zero,
  input  logic                     i_k_quarter,
  output logic signed [DATA_W-1:0] o_x0_re,
  output logic signed [DATA_W-1:0] o_x0_im,
  output logic signed [DATA_W-1:0] o_x1_re,
  output logic signed [DATA_W-1:0] o_x1_im,
  output logic                     o_ovf
);

  localparam int PW = 2 * DATA_W + 1;
  localparam int SW = DATA_W + 1;
  localparam logic signed [PW-1:0] P_MAX = PW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PW-1:0] P_MIN = ~P_MAX;
  localparam logic signed [PW-1:0] P_RND = PW'(2 ** (DATA_W - 2));
  localparam logic signed [SW-1:0] S_MAX = SW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

  // Results carry their saturation flag in the top bit
  function automatic logic [DATA_W:0] sat_p(input logic signed [PW-1:0] v);
    if (v > P_MAX) return {1'b1, P_MAX[DATA_W-1:0]};
    if (v < P_MIN) return {1'b1, P_MIN[DATA_W-1:0]};
    return {1'b0, v[DATA_W-1:0]};
  endfunction

  function automatic logic [DATA_W:0] fit_s(input logic signed [SW-1:0] v);
    if (SCALE != 0) return {1'b0, v[DATA_W:1]};
    if (v > S_MAX) return {1'b1, S_MAX[DATA_W-1:0]};
    if (v < S_MIN) return {1'b1, S_MIN[DATA_W-1:0]};
    return {1'b0, v[DATA_W-1:0]};
  endfunction

  logic signed [PW-1:0] w_pr, w_pi;
  logic [DATA_W:0]      w_pr_sat, w_pi_sat;
  logic signed [SW-1:0] w_wb_re, w_wb_im;
  logic signed [SW-1:0] w_s0_re, w_s0_im, w_s1_re, w_s1_im;
  logic [DATA_W:0]      w_r0_re, w_r0_im, w_r1_re, w_r1_im;
  logic                 w_mul_used;

  always_comb begin
    w_pr = PW'(i_w_cos) * PW'(i_b_re) + PW'(i_w_sin) * PW'(i_b_im);
    w_pi = PW'(i_w_cos) * PW'(i_b_im) - PW'(i_w_sin) * PW'(i_b_re);
    w_pr_sat = sat_p((w_pr + P_RND) >>> (DATA_W - 1));
    w_pi_sat = sat_p((w_pi + P_RND) >>> (DATA_W - 1));

    w_mul_used = 1'b0;
    if (i_k_zero) begin
      w_wb_re = SW'(i_b_re);
      w_wb_im = SW'(i_b_im);
    end else if (i_k_quarter) begin
      // -j*B kept at SW bits so negating the most negative code is exact
      w_wb_re = SW'(i_b_im);
      w_wb_im = -SW'(i_b_re);
    end else begin
      w_mul_used = 1'b1;
      w_wb_re = SW'($signed(w_pr_sat[DATA_W-1:0]));
      w_wb_im = SW'($signed(w_pi_sat[DATA_W-1:0]));
    end

    w_s0_re = SW'(i_a_re) + w_wb_re;
    w_s0_im = SW'(i_a_im) + w_wb_im;
    w_s1_re = SW'(i_a_re) - w_wb_re;
    w_s1_im = SW'(i_a_im) - w_wb_im;

    w_r0_re = fit_s(w_s0_re);
    w_r0_im = fit_s(w_s0_im);
    w_r1_re = fit_s(w_s1_re);
    w_r1_im = fit_s(w_s1_im);

    o_x0_re = $signed(w_r0_re[DATA_W-1:0]);
    o_x0_im = $signed(w_r0_im[DATA_W-1:0]);
    o_x1_re = $signed(w_r1_re[DATA_W-1:0]);
    o_x1_im = $signed(w_r1_im[DATA_W-1:0]);
    o_ovf   = (w_mul_used & (w_pr_sat[DATA_W] | w_pi_sat[DATA_W]))
            | w_r0_re[DATA_W] | w_r0_im[DATA_W] | w_r1_re[DATA_W] | w_r1_im[DATA_W];
  end

endmodule

// File: rtl/fft_radix2_stream.sv
// Streaming in-place radix-2 DIT FFT: bit-reversed load, one butterfly per
// cycle, natural-order unload with valid/ready back-pressure.
module fft_radix2_stream
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 3,
  parameter int SCALE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic [LOG2N-1:0]         out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     ovf
);

  localparam int N = 1 << LOG2N;

  logic signed [DATA_W-1:0] r_re [N];
  logic signed [DATA_W-1:0] r_im [N];

  fft_state_t               r_state;
  logic [LOG2N-1:0]         r_cnt;
  logic [2:0]               r_stage;
  logic [LOG2N-2:0]         r_bfly;
  logic                     r_out_valid, r_out_last, r_busy, r_ovf;
  logic signed [DATA_W-1:0] r_out_real, r_out_imag;
  logic [LOG2N-1:0]         r_out_index;

  logic [LOG2N-1:0]         w_b, w_h, w_j, w_top, w_bot, w_k, w_wr_addr, w_next_idx;
  logic [4:0]               w_tw_idx;
  logic signed [DATA_W-1:0] w_cos, w_sin;
  logic                     w_k_zero, w_k_quarter, w_load_hs, w_bfly_ovf;
  logic signed [DATA_W-1:0] w_x0_re, w_x0_im, w_x1_re, w_x1_im;

  assign in_ready  = (r_state == ST_LOAD) && reset;
  assign w_load_hs = in_valid && in_ready;
  assign w_wr_addr = LOG2N'(bitrev(6'(r_cnt), LOG2N));
  assign w_next_idx = r_out_index + LOG2N'(1);

  // top = (b>>s)*2h + j, bot = top + h, k = j*(N/2h)
  always_comb begin
    w_b      = {1'b0, r_bfly};
    w_h      = LOG2N'(1) << r_stage;
    w_j      = w_b & (w_h - LOG2N'(1));
    w_top    = ((w_b >> r_stage) << (r_stage + 3'd1)) | w_j;
    w_bot    = w_top | w_h;
    w_k      = w_j << (3'(LOG2N - 1) - r_stage);
    w_tw_idx = 5'(w_k) << (6 - LOG2N);
  end

  assign w_k_zero    = (w_k == '0);
  assign w_k_quarter = (w_k == LOG2N'(N / 4));
  assign w_cos       = DATA_W'(tw_q(COS_TAB[w_tw_idx], DATA_W));
  assign w_sin       = DATA_W'(tw_q(SIN_TAB[w_tw_idx], DATA_W));

  fft_bfly_unit #(.DATA_W(DATA_W), .SCALE(SCALE)) u_bfly (
    .i_a_re      (r_re[w_top]),
    .i_a_im      (r_im[w_top]),
    .i_b_re      (r_re[w_bot]),
    .i_b_im      (r_im[w_bot]),
    .i_w_cos     (w_cos),
    .i_w_sin     (w_sin),
    .i_k_zero    (w_k_zero),
    .i_k_quarter (w_k_quarter),
    .o_x0_re     (w_x0_re),
    .o_x0_im     (w_x0_im),
    .o_x1_re     (w_x1_re),
    .o_x1_im     (w_x1_im),
    .o_ovf       (w_bfly_ovf)
  );

  always_ff @(posedge clk) begin
    if (w_load_hs) begin
      r_re[w_wr_addr] <= in_real;
      r_im[w_wr_addr] <= in_imag;
    end else if (r_state == ST_COMPUTE) begin
      r_re[w_top] <= w_x0_re;
      r_im[w_top] <= w_x0_im;
      r_re[w_bot] <= w_x1_re;
      r_im[w_bot] <= w_x1_im;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_LOAD;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_bfly      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
      r_out_index <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_load_hs) begin
            if (r_cnt == '0) r_ovf <= 1'b0;
            r_cnt <= r_cnt + LOG2N'(1);
            if (r_cnt == LOG2N'(N - 1)) begin
              r_state <= ST_COMPUTE;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (w_bfly_ovf) r_ovf <= 1'b1;
          if (r_bfly == '1) begin
            r_bfly <= '0;
            if (r_stage == 3'(LOG2N - 1)) begin
              // bin 0 is final well before the last butterfly, so it can be presented now
              r_stage     <= '0;
              r_state     <= ST_UNLOAD;
              r_out_valid <= 1'b1;
              r_out_real  <= r_re[0];
              r_out_imag  <= r_im[0];
              r_out_index <= '0;
              r_out_last  <= 1'b0;
            end else begin
              r_stage <= r_stage + 3'd1;
            end
          end else begin
            r_bfly <= r_bfly + 1'b1;
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_state     <= ST_LOAD;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_cnt       <= '0;
            end else begin
              r_out_index <= w_next_idx;
              r_out_real  <= r_re[w_next_idx];
              r_out_imag  <= r_im[w_next_idx];
              r_out_last  <= (w_next_idx == LOG2N'(N - 1));
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_real  = r_out_real;
  assign out_imag  = r_out_imag;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fft_radix2_stream.sv
// Directed and random frames through three FFT configurations, checked
// against a floating-point DFT model.
module tb_fft_radix2_stream;

  localparam int  DW = 16;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [1:0]           sel;
  logic                 drv_valid, drv_ready;
  logic signed [DW-1:0] drv_re, drv_im;

  logic [2:0]           iv, ordy, irdy, ov, ol, bs, of;
  logic signed [DW-1:0] ore [3];
  logic signed [DW-1:0] oim [3];
  logic [2:0]           ix0, ix1;
  logic [3:0]           ix2;

  assign iv[0] = drv_valid && (sel == 2'd0);
  assign iv[1] = drv_valid && (sel == 2'd1);
  assign iv[2] = drv_valid && (sel == 2'd2);
  assign ordy[0] = drv_ready && (sel == 2'd0);
  assign ordy[1] = drv_ready && (sel == 2'd1);
  assign ordy[2] = drv_ready && (sel == 2'd2);

  fft_radix2_stream #(.DATA_W(DW), .LOG2N(3), .SCALE(0)) u_n8s0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_real(drv_re), .in_imag(drv_im), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_real(ore[0]), .out_imag(oim[0]), .out_index(ix0), .out_last(ol[0]),
    .busy(bs[0]), .ovf(of[0]));

  fft_radix2_stream #(.DATA_W(DW), .LOG2N(3), .SCALE(1)) u_n8s1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_real(drv_re), .in_imag(drv_im), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_real(ore[1]), .out_imag(oim[1]), .out_index(ix1), .out_last(ol[1]),
    .busy(bs[1]), .ovf(of[1]));

  fft_radix2_stream #(.DATA_W(DW), .LOG2N(4), .SCALE(1)) u_n16s1 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_real(drv_re), .in_imag(drv_im), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_real(ore[2]), .out_imag(oim[2]), .out_index(ix2), .out_last(ol[2]),
    .busy(bs[2]), .ovf(of[2]));

  int m_irdy, m_ov, m_ol, m_bs, m_of, m_re, m_im, m_ix;
  always_comb begin
    m_irdy = int'(irdy[sel]);
    m_ov   = int'(ov[sel]);
    m_ol   = int'(ol[sel]);
    m_bs   = int'(bs[sel]);
    m_of   = int'(of[sel]);
    m_re   = int'(ore[sel]);
    m_im   = int'(oim[sel]);
    case (sel)
      2'd0:    m_ix = int'(ix0);
      2'd1:    m_ix = int'(ix1);
      default: m_ix = int'(ix2);
    endcase
  end

  int n_err = 0;
  int n_chk = 0;
  int x_re [16], x_im [16];
  int g_re [16], g_im [16], g_ix [16], g_last [16];
  int compute_cycles;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic near(input string tag, input int obs, input int exp, input int tol);
    n_chk++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic real clampr(input real v);
    if (v > 32767.0) return 32767.0;
    if (v < -32768.0) return -32768.0;
    return v;
  endfunction

  task automatic drive_samples(input int n);
    for (int i = 0; i < n; i++) begin
      drv_valid = 1'b1;
      drv_re    = DW'(x_re[i]);
      drv_im    = DW'(x_im[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input int n, input bit hold);
    int t;
    t = 0;
    while (m_irdy == 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_in_load", m_irdy, 1);
    drive_samples(n);
    drv_valid = hold;
    compute_cycles = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (m_ov != 0) break;
      if (m_bs != 0) compute_cycles++;
      if (hold) chk("in_ready_compute", m_irdy, 0);
    end
  endtask

  task automatic recv(input int n, input bit stall, input bit hold);
    int hs, s_re, s_im, s_ix, s_last;
    bit prev;
    hs = 0; prev = 1'b0;
    s_re = 0; s_im = 0; s_ix = 0; s_last = 0;
    for (int c = 0; c < 400 && hs < n; c++) begin
      if (prev) begin
        chk("stall_hold_re", m_re, s_re);
        chk("stall_hold_im", m_im, s_im);
        chk("stall_hold_idx", m_ix, s_ix);
        chk("stall_hold_last", m_ol, s_last);
      end
      drv_ready = stall ? ((c % 2) == 1) : 1'b1;
      if (hold) chk("in_ready_unload", m_irdy, 0);
      if (m_ov != 0) begin
        if (drv_ready) begin
          g_re[hs] = m_re; g_im[hs] = m_im; g_ix[hs] = m_ix; g_last[hs] = m_ol;
          hs++;
          prev = 1'b0;
        end else begin
          s_re = m_re; s_im = m_im; s_ix = m_ix; s_last = m_ol;
          prev = 1'b1;
        end
      end
      @(negedge clk);
    end
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    chk("handshake_count", hs, n);
    chk("out_valid_after_last", m_ov, 0);
    chk("busy_after_last", m_bs, 0);
    chk("in_ready_after_last", m_irdy, 1);
    for (int i = 0; i < hs; i++) begin
      chk($sformatf("out_index[%0d]", i), g_ix[i], i);
      chk($sformatf("out_last[%0d]", i), g_last[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  task automatic model_check(input int n, input bit scale, input int tol, input string tg);
    real sr, si, th;
    for (int k = 0; k < n; k++) begin
      sr = 0.0; si = 0.0;
      for (int t = 0; t < n; t++) begin
        th = 2.0 * PI * real'(k) * real'(t) / real'(n);
        sr += real'(x_re[t]) * $cos(th) + real'(x_im[t]) * $sin(th);
        si += real'(x_im[t]) * $cos(th) - real'(x_re[t]) * $sin(th);
      end
      if (scale) begin
        sr = sr / real'(n);
        si = si / real'(n);
      end else begin
        sr = clampr(sr);
        si = clampr(si);
      end
      near($sformatf("%s X%0d.re", tg, k), g_re[k], rnd(sr), tol);
      near($sformatf("%s X%0d.im", tg, k), g_im[k], rnd(si), tol);
    end
  endtask

  task automatic set_impulse(input int n, input int amp);
    for (int i = 0; i < 16; i++) begin
      x_re[i] = (i == 0) ? amp : 0;
      x_im[i] = 0;
    end
  endtask

  task automatic set_dc(input int n, input int amp);
    for (int i = 0; i < 16; i++) begin
      x_re[i] = (i < n) ? amp : 0;
      x_im[i] = 0;
    end
  endtask

  task automatic set_random(input int span);
    for (int i = 0; i < 16; i++) begin
      x_re[i] = int'($urandom_range(2 * span)) - span;
      x_im[i] = int'($urandom_range(2 * span)) - span;
    end
  endtask

  initial begin
    reset = 1'b0; sel = 2'd0;
    drv_valid = 1'b0; drv_ready = 1'b0; drv_re = '0; drv_im = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      chk("rst_out_valid", m_ov, 0);
      chk("rst_busy", m_bs, 0);
      chk("rst_ovf", m_of, 0);
      chk("rst_in_ready", m_irdy, 0);
      chk("rst_out_real", m_re, 0);
      chk("rst_out_index", m_ix, 0);
      chk("rst_out_last", m_ol, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // impulse, N=8, no scaling
    sel = 2'd0; set_impulse(8, 1000);
    send(8, 1'b0);
    chk("n8_compute_cycles", compute_cycles, 12);
    recv(8, 1'b0, 1'b0);
    model_check(8, 1'b0, 0, "impulse");
    chk("impulse_ovf", m_of, 0);

    // DC, N=8, scaled
    sel = 2'd1; set_dc(8, 1000);
    send(8, 1'b0);
    chk("n8s1_compute_cycles", compute_cycles, 12);
    recv(8, 1'b0, 1'b0);
    model_check(8, 1'b1, 0, "dc_scaled");

    // DC driving saturation, then an impulse must clear ovf
    sel = 2'd0; set_dc(8, 8192);
    send(8, 1'b0);
    recv(8, 1'b0, 1'b0);
    chk("sat_X0", g_re[0], 32767);
    model_check(8, 1'b0, 0, "dc_sat");
    chk("sat_ovf", m_of, 1);
    set_impulse(8, 1000);
    send(8, 1'b0);
    recv(8, 1'b0, 1'b0);
    model_check(8, 1'b0, 0, "post_sat");
    chk("post_sat_ovf", m_of, 0);

    // back-pressure with in_valid held high throughout
    sel = 2'd1; set_random(16000);
    send(8, 1'b1);
    recv(8, 1'b1, 1'b1);
    model_check(8, 1'b1, 3, "stall");

    // reset during the 5th compute cycle aborts the frame
    sel = 2'd0; set_dc(8, 8192);
    @(posedge clk); #1;
    drive_samples(8);
    drv_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", m_ov, 0);
    chk("abort_busy", m_bs, 0);
    chk("abort_ovf", m_of, 0);
    chk("abort_in_ready", m_irdy, 0);
    chk("abort_out_index", m_ix, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    set_impulse(8, 1000);
    send(8, 1'b0);
    chk("after_abort_compute_cycles", compute_cycles, 12);
    recv(8, 1'b0, 1'b0);
    model_check(8, 1'b0, 0, "after_abort");
    chk("after_abort_ovf", m_of, 0);

    // alternating sign, N=16
    sel = 2'd2;
    for (int i = 0; i < 16; i++) begin
      x_re[i] = (i % 2 == 0) ? 1024 : -1024;
      x_im[i] = 0;
    end
    send(16, 1'b0);
    chk("n16_compute_cycles", compute_cycles, 32);
    recv(16, 1'b0, 1'b0);
    chk("alt_X8.re", g_re[8], 1024);
    chk("alt_X8.im", g_im[8], 0);
    model_check(16, 1'b1, 1, "alt");

    // random frames
    for (int f = 0; f < 3; f++) begin
      sel = 2'd2; set_random(16000);
      send(16, 1'b0);
      recv(16, (f == 1), 1'b0);
      model_check(16, 1'b1, 3, $sformatf("rand16_%0d", f));
    end
    sel = 2'd0; set_random(1000);
    send(8, 1'b0);
    recv(8, 1'b0, 1'b0);
    model_check(8, 1'b0, 3, "rand8_noscale");
    chk("rand8_ovf", m_of, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
